// File: rtl/control_sequencer.sv
// Instruction sequencer for the 8-bit accumulator computer.
// Moore FSM plus a memory-latency wait counter driving datapath strobes.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   IR, CCR_Result      current opcode and N/Z/V/C flags
//   *_Load, PC_Inc      datapath load strobes
//   ALU_Sel, Bus1_Sel,  ALU operation and bus source selects
//   Bus2_Sel
//   write               memory write strobe
//   instr_done          final cycle of each instruction
//   illegal             pulse on an unsupported opcode
module control_sequencer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        FETCH_0, FETCH_W, FETCH_2, DECODE,
        OPA, OPA_W, LD_IMM, DIR_ADDR,
        DIR_W, LD_DIR, ST, BR_LOAD,
        BR_SKIP, ALU, ILLEGAL
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;

    logic is_ldimm, is_lddir, is_st, is_br, is_alu;
    logic use_b, taken, first, in_wait, enter_wait;

    assign is_ldimm = (IR == 8'h86) || (IR == 8'h88);
    assign is_lddir = (IR == 8'h87) || (IR == 8'h89);
    assign is_st    = (IR == 8'h96) || (IR == 8'h97);
    assign is_br    = (IR >= 8'h20) && (IR <= 8'h28);
    assign is_alu   = (IR >= 8'h42) && (IR <= 8'h49);
    assign use_b    = (IR == 8'h88) || (IR == 8'h89)
                   || (IR == 8'h97);

    // first cycle of any wait state: counter still holds its load value
    assign first = (cnt == LAT_M1);

    always_comb begin
        taken = 1'b0;
        case (IR)
            8'h20:   taken = 1'b1;
            8'h21:   taken = CCR_Result[3];
            8'h22:   taken = ~CCR_Result[3];
            8'h23:   taken = CCR_Result[2];
            8'h24:   taken = ~CCR_Result[2];
            8'h25:   taken = CCR_Result[1];
            8'h26:   taken = ~CCR_Result[1];
            8'h27:   taken = CCR_Result[0];
            8'h28:   taken = ~CCR_Result[0];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH_0;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        IR_Load    = 1'b0;
        MAR_Load   = 1'b0;
        PC_Load    = 1'b0;
        PC_Inc     = 1'b0;
        A_Load     = 1'b0;
        B_Load     = 1'b0;
        CCR_Load   = 1'b0;
        ALU_Sel    = 3'b000;
        Bus1_Sel   = 2'b00;
        Bus2_Sel   = 2'b00;
        write      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        in_wait    = 1'b0;
        enter_wait = 1'b0;

        case (state)
            FETCH_0: begin
                MAR_Load = 1'b1;
                Bus2_Sel = 2'b01;
                state_n  = FETCH_W;
            end
            FETCH_W: begin
                in_wait = 1'b1;
                PC_Inc  = first;
                if (cnt == 4'd0) state_n = FETCH_2;
            end
            FETCH_2: begin
                IR_Load  = 1'b1;
                Bus2_Sel = 2'b10;
                state_n  = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    is_ldimm, is_lddir, is_st: state_n = OPA;
                    is_br:   state_n = taken ? OPA : BR_SKIP;
                    is_alu:  state_n = ALU;
                    default: state_n = ILLEGAL;
                endcase
            end
            OPA: begin
                MAR_Load = 1'b1;
                Bus2_Sel = 2'b01;
                state_n  = OPA_W;
            end
            OPA_W: begin
                in_wait = 1'b1;
                // branch operand is consumed by PC_Load, not stepped over
                PC_Inc  = first && !is_br;
                if (cnt == 4'd0) begin
                    unique case (1'b1)
                        is_ldimm: state_n = LD_IMM;
                        is_br:    state_n = BR_LOAD;
                        default:  state_n = DIR_ADDR;
                    endcase
                end
            end
            LD_IMM, LD_DIR: begin
                A_Load     = !use_b;
                B_Load     = use_b;
                Bus2_Sel   = 2'b10;
                instr_done = 1'b1;
                state_n    = FETCH_0;
            end
            DIR_ADDR: begin
                MAR_Load = 1'b1;
                Bus2_Sel = 2'b10;
                state_n  = is_st ? ST : DIR_W;
            end
            DIR_W: begin
                in_wait = 1'b1;
                if (cnt == 4'd0) state_n = LD_DIR;
            end
            ST: begin
                write      = 1'b1;
                Bus1_Sel   = use_b ? 2'b10 : 2'b01;
                Bus2_Sel   = 2'b01;
                instr_done = 1'b1;
                state_n    = FETCH_0;
            end
            BR_LOAD: begin
                PC_Load    = 1'b1;
                Bus2_Sel   = 2'b10;
                instr_done = 1'b1;
                state_n    = FETCH_0;
            end
            BR_SKIP: begin
                PC_Inc     = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH_0;
            end
            ALU: begin
                CCR_Load   = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH_0;
                case (IR)
                    8'h42:   ALU_Sel = 3'b000;
                    8'h43:   ALU_Sel = 3'b001;
                    8'h44:   ALU_Sel = 3'b010;
                    8'h45:   ALU_Sel = 3'b011;
                    8'h46,
                    8'h47:   ALU_Sel = 3'b100;
                    default: ALU_Sel = 3'b101;
                endcase
                if (IR == 8'h47 || IR == 8'h49) begin
                    Bus1_Sel = 2'b10;
                    B_Load   = 1'b1;
                end else begin
                    Bus1_Sel = 2'b01;
                    A_Load   = 1'b1;
                end
            end
            ILLEGAL: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
                state_n    = FETCH_0;
            end
            default: state_n = FETCH_0;
        endcase

        enter_wait = (state_n != state)
                  && (state_n == FETCH_W
                   || state_n == OPA_W
                   || state_n == DIR_W);
        if (enter_wait)
            cnt_n = LAT_M1;
        else if (in_wait && cnt != 4'd0)
            cnt_n = cnt - 4'd1;

        // outputs are quiet for the whole time reset is held
        if (reset) begin
            IR_Load    = 1'b0;
            MAR_Load   = 1'b0;
            PC_Load    = 1'b0;
            PC_Inc     = 1'b0;
            A_Load     = 1'b0;
            B_Load     = 1'b0;
            CCR_Load   = 1'b0;
            ALU_Sel    = 3'b000;
            Bus1_Sel   = 2'b00;
            Bus2_Sel   = 2'b00;
            write      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer at MEM_LAT=1 and MEM_LAT=3.
// Outputs packed as {strobes[7], ALU_Sel, Bus1, Bus2, write, done, illegal}.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IR = 8'h00;
    logic [3:0] CCR_Result = 4'h0;

    logic [6:0] s1, s3;
    logic [2:0] alu1, alu3;
    logic [1:0] b11, b21, b13, b23;
    logic [2:0] f1, f3;
    logic [16:0] o1, o3;

    int nvec = 0;
    int nmis = 0;

    logic [16:0] expq[$];

    // hand-built output words per state
    localparam logic [16:0] Z   = 17'b0;
    localparam logic [16:0] F0  = 17'b0100000_000_00_01_000;
    localparam logic [16:0] FW1 = 17'b0001000_000_00_00_000;
    localparam logic [16:0] F2  = 17'b1000000_000_00_10_000;
    localparam logic [16:0] DAD = 17'b0100000_000_00_10_000;
    localparam logic [16:0] LDA = 17'b0000100_000_00_10_010;
    localparam logic [16:0] LDB = 17'b0000010_000_00_10_010;
    localparam logic [16:0] STB = 17'b0000000_000_10_01_110;
    localparam logic [16:0] BRL = 17'b0010000_000_00_10_010;
    localparam logic [16:0] SKP = 17'b0001000_000_00_00_010;
    localparam logic [16:0] A43 = 17'b0000101_001_01_00_010;
    localparam logic [16:0] A47 = 17'b0000011_100_10_00_010;
    localparam logic [16:0] ILL = 17'b0000000_000_00_00_011;

    control_sequencer #(.MEM_LAT(1)) u_l1 (
        .clock(clock), .reset(reset),
        .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(s1[6]), .MAR_Load(s1[5]),
        .PC_Load(s1[4]), .PC_Inc(s1[3]),
        .A_Load(s1[2]), .B_Load(s1[1]),
        .CCR_Load(s1[0]), .ALU_Sel(alu1),
        .Bus1_Sel(b11), .Bus2_Sel(b21),
        .write(f1[2]), .instr_done(f1[1]),
        .illegal(f1[0])
    );

    control_sequencer #(.MEM_LAT(3)) u_l3 (
        .clock(clock), .reset(reset),
        .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(s3[6]), .MAR_Load(s3[5]),
        .PC_Load(s3[4]), .PC_Inc(s3[3]),
        .A_Load(s3[2]), .B_Load(s3[1]),
        .CCR_Load(s3[0]), .ALU_Sel(alu3),
        .Bus1_Sel(b13), .Bus2_Sel(b23),
        .write(f3[2]), .instr_done(f3[1]),
        .illegal(f3[0])
    );

    assign o1 = {s1, alu1, b11, b21, f1};
    assign o3 = {s3, alu3, b13, b23, f3};

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [16:0] got,
                         input logic [16:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got %b want %b", tag, got, exp);
        end
    endtask

    // reset, then compare one output word per cycle against expq
    task automatic run(input string name,
                       input logic [7:0] op,
                       input logic [3:0] ccr,
                       input bit slow);
        @(negedge clock);
        reset = 1'b1;
        IR = op;
        CCR_Result = ccr;
        #1;
        check({name, "/rst"}, slow ? o3 : o1, Z);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        foreach (expq[i]) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
            check($sformatf("%s/c%0d", name, i + 1),
                  slow ? o3 : o1, expq[i]);
        end
    endtask

    logic [7:0] br_op[9] = '{8'h20, 8'h21, 8'h22, 8'h23,
                             8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    int         br_bit[9] = '{0, 3, 3, 2, 2, 1, 1, 0, 0};
    bit         br_want[9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};

    initial begin
        expq = '{F0, FW1, F2, Z, F0, FW1, LDA, F0};
        run("lda_imm", 8'h86, 4'h0, 1'b0);

        expq = '{F0, FW1, F2, Z, F0, FW1, DAD, Z, LDA, F0};
        run("lda_dir", 8'h87, 4'h0, 1'b0);

        expq = '{F0, FW1, Z, Z, F2, Z, F0, FW1, Z, Z,
                 DAD, Z, Z, Z, LDB, F0};
        run("ldb_dir_l3", 8'h89, 4'h0, 1'b1);

        expq = '{F0, FW1, F2, Z, F0, FW1, DAD, STB, F0};
        run("stb_dir", 8'h97, 4'h0, 1'b0);

        for (int k = 0; k < 9; k++) begin
            for (int v = 0; v < 2; v++) begin
                logic [3:0] ccr;
                bit         tk;
                ccr = 4'(1 << br_bit[k]);
                if (v == 0) ccr = ~ccr;
                tk = (k == 0) || (ccr[br_bit[k]] == br_want[k]);
                if (tk)
                    expq = '{F0, FW1, F2, Z, F0, Z, BRL, F0};
                else
                    expq = '{F0, FW1, F2, Z, SKP, F0};
                run($sformatf("br%h_%h", br_op[k], ccr),
                    br_op[k], ccr, 1'b0);
            end
        end

        expq = '{F0, FW1, F2, Z, A43, F0};
        run("sub_ab", 8'h43, 4'h0, 1'b0);

        expq = '{F0, FW1, F2, Z, A47, F0};
        run("incb", 8'h47, 4'h0, 1'b0);

        expq = '{F0, FW1, F2, Z, ILL, F0};
        run("illegal", 8'hFF, 4'h0, 1'b0);

        // reset while the L=3 instance sits in DIR_W
        expq = '{F0, FW1, Z, Z, F2, Z, F0, FW1, Z, Z, DAD, Z};
        run("dirw_abort", 8'h87, 4'h0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1 check("abort/held", o3, Z);
        @(posedge clock);
        #1 check("abort/edge", o3, Z);
        reset = 1'b0;
        #1 check("abort/f0", o3, F0);
        @(posedge clock);
        #1 check("abort/fw", o3, FW1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule
